// File: rtl/ipdc_pkg.sv
// Shared constants and types for the ipdc command front-end.
// Op codes follow the ipdc instruction set; only OP_LOAD is special to the scheduler.
package ipdc_pkg;

  localparam int PIX_W         = 24;
  localparam int OP_W          = 4;
  localparam int DEF_PIX_COUNT = 256;
  localparam int DEF_CMD_DEPTH = 8;

  localparam logic [OP_W-1:0] OP_LOAD        = 4'h0;
  localparam logic [OP_W-1:0] OP_SHIFT_RIGHT = 4'h1;
  localparam logic [OP_W-1:0] OP_SHIFT_LEFT  = 4'h2;
  localparam logic [OP_W-1:0] OP_SHIFT_UP    = 4'h3;
  localparam logic [OP_W-1:0] OP_SHIFT_DOWN  = 4'h4;
  localparam logic [OP_W-1:0] OP_SCALE_DOWN  = 4'h5;
  localparam logic [OP_W-1:0] OP_SCALE_UP    = 4'h6;
  localparam logic [OP_W-1:0] OP_MEDIAN      = 4'h7;
  localparam logic [OP_W-1:0] OP_YCBCR       = 4'h8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } sched_state_e;

endpackage

// File: rtl/ipdc_cmd_fifo.sv
// Synchronous op-code FIFO with registered count; no write-to-read bypass.
// DEPTH must be a power of two so the pointers wrap naturally.
module ipdc_cmd_fifo
  import ipdc_pkg::*;
#(
  parameter int DEPTH = DEF_CMD_DEPTH,
  parameter int W     = OP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ipdc_cmd_scheduler.sv
// Front-end for ipdc: queues host ops, issues one per ipdc ready token and
// streams one image of pixels into ipdc after each LOAD op.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | pop/issue ops when a ready token is held; pixel path closed
//   LOAD  | host pixels pass straight through to ipdc until PIX_COUNT beats
module ipdc_cmd_scheduler
  import ipdc_pkg::*;
#(
  parameter int CMD_DEPTH = DEF_CMD_DEPTH,
  parameter int PIX_COUNT = DEF_PIX_COUNT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  input  logic [3:0]        i_cmd_mode,
  output logic              o_cmd_ready,
  input  logic              i_pix_valid,
  input  logic [PIX_W-1:0]  i_pix_data,
  output logic              o_pix_ready,
  output logic              o_op_valid,
  output logic [3:0]        o_op_mode,
  input  logic              i_op_ready,
  output logic              o_in_valid,
  output logic [PIX_W-1:0]  o_in_data,
  input  logic              i_in_ready,
  output logic              o_busy,
  output logic              o_err
);

  localparam int CNT_W = $clog2(PIX_COUNT) + 1;
  localparam int FCW   = $clog2(CMD_DEPTH) + 1;

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_LOAD = ST_LOAD;

  logic [0:0]       state;
  logic             tok;
  logic             loaded;
  logic             load_issued;
  logic [CNT_W-1:0] beat_cnt;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       fifo_head;
  logic [FCW-1:0]   fifo_count;

  logic             in_load;
  logic             head_is_load;
  logic             issue;
  logic             beat;
  logic             last_beat;

  ipdc_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (OP_W)
  ) u_cmd_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (i_cmd_valid && o_cmd_ready),
    .push_data (i_cmd_mode),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_load      = (state == S_LOAD);
  assign o_cmd_ready  = !fifo_full;
  assign o_busy       = in_load || (fifo_count != '0);

  // A popped non-LOAD op before any image is loaded is dropped, not issued.
  assign fifo_pop     = (state == S_IDLE) && tok && !fifo_empty;
  assign head_is_load = (fifo_head == OP_LOAD);
  assign issue        = fifo_pop && (head_is_load || loaded);

  assign beat         = in_load && i_pix_valid && i_in_ready;
  assign last_beat    = beat && (beat_cnt == CNT_W'(PIX_COUNT - 1));

  assign o_in_valid   = in_load ? i_pix_valid : 1'b0;
  assign o_in_data    = in_load ? i_pix_data  : '0;
  assign o_pix_ready  = in_load ? i_in_ready  : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      tok         <= 1'b0;
      loaded      <= 1'b0;
      load_issued <= 1'b0;
      beat_cnt    <= '0;
      o_op_valid  <= 1'b0;
      o_op_mode   <= OP_LOAD;
      o_err       <= 1'b0;
    end else begin
      o_op_valid  <= issue;
      o_op_mode   <= issue ? fifo_head : OP_LOAD;
      load_issued <= issue && head_is_load;

      // Issuing consumes the token even if ipdc re-signals ready this cycle.
      if (issue) begin
        tok <= 1'b0;
      end else if (i_op_ready) begin
        tok <= 1'b1;
      end

      if (issue && head_is_load) loaded <= 1'b1;
      if (fifo_pop && !issue)    o_err  <= 1'b1;

      if (last_beat) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end

      // LOAD opens the cycle after the LOAD op pulse, not alongside it.
      case (state)
        S_IDLE:  if (load_issued) state <= S_LOAD;
        S_LOAD:  if (last_beat)   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipdc_cmd_scheduler.sv
// Self-checking bench for ipdc_cmd_scheduler: vector table, directed load /
// FIFO sequences and randomized traffic against a queue-based reference model.
module tb_ipdc_cmd_scheduler;

  localparam int PIX   = 256;
  localparam int DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic [3:0]  i_cmd_mode;
  logic        o_cmd_ready;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_pix_ready;
  logic        o_op_valid;
  logic [3:0]  o_op_mode;
  logic        i_op_ready;
  logic        o_in_valid;
  logic [23:0] o_in_data;
  logic        i_in_ready;
  logic        o_busy;
  logic        o_err;

  ipdc_cmd_scheduler dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_mode  (i_cmd_mode),
    .o_cmd_ready (o_cmd_ready),
    .i_pix_valid (i_pix_valid),
    .i_pix_data  (i_pix_data),
    .o_pix_ready (o_pix_ready),
    .o_op_valid  (o_op_valid),
    .o_op_mode   (o_op_mode),
    .i_op_ready  (i_op_ready),
    .o_in_valid  (o_in_valid),
    .o_in_data   (o_in_data),
    .i_in_ready  (i_in_ready),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       rst;
    logic       cv;
    logic [3:0] cm;
    logic       opr;
    logic       pv;
    logic       ir;
    logic [9:0] exp;   // {op_valid, op_mode, cmd_ready, busy, err, in_valid, pix_ready}
  } vec_t;

  vec_t vecs [13];

  // reference model state
  int         q [$];
  bit         m_tok, m_loaded, m_inload, m_err, m_pv, m_pl;
  logic [3:0] m_pm;
  int         m_beats;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_inputs();
    i_cmd_valid = 1'b0;
    i_cmd_mode  = 4'h0;
    i_pix_valid = 1'b0;
    i_pix_data  = 24'h0;
    i_op_ready  = 1'b0;
    i_in_ready  = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    clr_inputs();
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_tok = 0; m_loaded = 0; m_inload = 0; m_err = 0;
    m_pv = 0; m_pl = 0; m_pm = 4'h0; m_beats = 0;
  endtask

  // One clock edge of the specified behaviour, from the inputs seen before it.
  task automatic model_step(input bit rst, input bit cv, input logic [3:0] cm,
                            input bit opr, input bit pv, input bit ir);
    int sz;
    int h;
    bit enter;
    bit issued;
    if (rst) begin
      model_reset();
      return;
    end
    sz = q.size();
    enter = m_pl;
    issued = 0;
    m_pv = 0; m_pl = 0; m_pm = 4'h0;
    if (!m_inload && m_tok && sz > 0) begin
      h = q.pop_front();
      if (h == 0 || m_loaded) begin
        issued = 1; m_pv = 1; m_pm = 4'(h); m_tok = 0;
        if (h == 0) begin
          m_loaded = 1;
          m_pl = 1;
        end
      end else begin
        m_err = 1;
      end
    end
    if (!issued && opr) m_tok = 1;
    if (cv && sz < DEPTH) q.push_back(int'(cm));
    if (m_inload && pv && ir) begin
      m_beats++;
      if (m_beats == PIX) begin
        m_beats = 0;
        m_inload = 0;
      end
    end
    if (enter) m_inload = 1;
  endtask

  // Push a LOAD together with a ready pulse; returns in the first LOAD cycle.
  task automatic issue_load();
    int lat;
    lat = -1;
    i_op_ready = 1'b1; i_cmd_valid = 1'b1; i_cmd_mode = 4'h0;
    for (int k = 0; k < 6 && lat < 0; k++) begin
      @(negedge i_clk);
      if (o_op_valid) begin
        lat = k;
        chk("load_op_mode", 64'(o_op_mode), 64'h0);
      end
      step();
      i_op_ready = 1'b0; i_cmd_valid = 1'b0;
    end
    chk("load_issue_latency", 64'(lat), 64'd2);
  endtask

  task automatic stream_load(input bit toggle, input int abort_at);
    int beats;
    int lc;
    beats = 0; lc = 0;
    while (beats < PIX && lc < 1200) begin
      if (abort_at > 0 && beats == abort_at) begin
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_load_outputs",
            {o_op_valid, o_op_mode, o_in_valid, o_in_data, o_pix_ready, o_busy, o_err}, 64'h0);
        step();
        i_pix_valid = 1'b0; i_in_ready = 1'b0;
        return;
      end
      i_pix_valid = 1'b1;
      i_pix_data  = 24'(beats);
      i_in_ready  = toggle ? lc[0] : 1'b1;
      @(negedge i_clk);
      chk("load_beat", {o_in_valid, o_pix_ready, o_in_data}, {1'b1, i_in_ready, i_pix_data});
      if (i_in_ready) beats++;
      lc++;
      step();
    end
    chk("load_cycles", 64'(lc), toggle ? 64'd512 : 64'd256);
    @(negedge i_clk);
    chk("load_exit", {o_in_valid, o_pix_ready, o_busy}, 64'h0);
    i_pix_valid = 1'b0; i_in_ready = 1'b0;
    step();
  endtask

  initial begin
    int spurious;
    logic r_rst, r_cv, r_opr, r_pv, r_ir;
    logic [3:0] r_cm;

    // rst cv cm opr pv ir | op_valid mode cmd_ready busy err in_valid pix_ready
    vecs[0]  = {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'b0_0000_1_0_0_0_0};
    vecs[1]  = {1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 10'b0_0000_1_0_0_0_0};
    vecs[2]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'b0_0000_1_1_0_0_0};
    vecs[3]  = {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 10'b0_0000_1_0_1_0_0};
    vecs[4]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'b0_0000_1_1_1_0_0};
    vecs[5]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 10'b1_0000_1_0_1_0_0};
    vecs[6]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 10'b0_0000_1_1_1_1_0};
    vecs[7]  = {1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 10'b0_0000_1_1_1_0_0};
    vecs[8]  = {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 10'b0_0000_1_1_1_0_0};
    vecs[9]  = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 10'b0_0000_1_1_1_0_1};
    vecs[10] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 10'b0_0000_1_1_1_0_0};
    vecs[11] = {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 10'b0_0000_1_1_1_1_1};
    vecs[12] = {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 10'b0_0000_1_0_0_0_0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      i_rst = vecs[i].rst; i_cmd_valid = vecs[i].cv; i_cmd_mode = vecs[i].cm;
      i_op_ready = vecs[i].opr; i_pix_valid = vecs[i].pv; i_in_ready = vecs[i].ir;
      i_pix_data = 24'hA5A5A5;
      @(negedge i_clk);
      chk($sformatf("vec%0d", i),
          {o_op_valid, o_op_mode, o_cmd_ready, o_busy, o_err, o_in_valid, o_pix_ready},
          64'(vecs[i].exp));
      step();
    end

    // token held while FIFO empty, then basic load
    do_reset();
    i_op_ready = 1'b1;
    step();
    i_op_ready = 1'b0;
    spurious = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_op_valid) spurious++;
      step();
    end
    chk("tok_hold_no_issue", 64'(spurious), 64'h0);
    i_cmd_valid = 1'b1; i_cmd_mode = 4'h0;
    @(negedge i_clk);
    chk("tok_push_t0", 64'(o_op_valid), 64'h0);
    step();
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    chk("tok_push_t1", 64'(o_op_valid), 64'h0);
    step();
    @(negedge i_clk);
    chk("tok_push_t2", {o_op_valid, o_op_mode}, 64'h10);
    step();
    stream_load(1'b0, 0);

    // backpressure: in_ready toggles starting low
    issue_load();
    stream_load(1'b1, 0);

    // fill the FIFO without tokens, then drain one op per token
    for (int k = 1; k <= 8; k++) begin
      i_cmd_valid = 1'b1; i_cmd_mode = 4'(k);
      @(negedge i_clk);
      chk("fill_ready", 64'(o_cmd_ready), 64'h1);
      step();
    end
    i_cmd_mode = 4'h9;
    repeat (3) begin
      @(negedge i_clk);
      chk("full_stall", {o_cmd_ready, o_op_valid}, 64'h0);
      step();
    end
    i_cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      i_op_ready = 1'b1;
      @(negedge i_clk);
      chk("drain_t0", 64'(o_op_valid), 64'h0);
      step();
      i_op_ready = 1'b0;
      @(negedge i_clk);
      chk("drain_t1", 64'(o_op_valid), 64'h0);
      step();
      @(negedge i_clk);
      chk($sformatf("drain_op%0d", k), {o_op_valid, o_op_mode}, {1'b1, 4'(k)});
      step();
      @(negedge i_clk);
      chk("drain_single_pulse", 64'(o_op_valid), 64'h0);
      step();
    end
    i_op_ready = 1'b1;
    step();
    i_op_ready = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_op_valid) spurious++;
      step();
    end
    chk("ninth_push_dropped", {28'(spurious), o_busy}, 64'h0);

    // reset at beat 100, then a full new load
    do_reset();
    issue_load();
    stream_load(1'b0, 100);
    issue_load();
    stream_load(1'b0, 0);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 499) == 0);
      r_cv  = ($urandom_range(0, 9) < 3);
      r_cm  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 8));
      r_opr = ($urandom_range(0, 9) < 2);
      r_pv  = ($urandom_range(0, 9) < 7);
      r_ir  = ($urandom_range(0, 9) < 7);
      i_rst = r_rst; i_cmd_valid = r_cv; i_cmd_mode = r_cm; i_op_ready = r_opr;
      i_pix_valid = r_pv; i_in_ready = r_ir; i_pix_data = 24'($urandom);
      @(negedge i_clk);
      chk("random_cycle",
          {o_op_valid, o_op_mode, o_cmd_ready, o_pix_ready, o_in_valid, o_in_data, o_busy, o_err},
          {m_pv, m_pm, (q.size() < DEPTH), (m_inload ? r_ir : 1'b0), (m_inload ? r_pv : 1'b0),
           (m_inload ? i_pix_data : 24'h0), (m_inload || q.size() > 0), m_err});
      model_step(r_rst, r_cv, r_cm, r_opr, r_pv, r_ir);
      step();
    end
    i_rst = 1'b0;
    clr_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
    $fatal(1);
  end

endmodule

// File: doc/ipdc_cmd_scheduler.md
# ipdc_cmd_scheduler

Upstream front-end for `ipdc`. It queues host op codes in a small FIFO and issues them one at a time as single-cycle `op_valid` pulses. It only issues an op after `ipdc` has signalled readiness. After issuing a load op it streams exactly one image of RGB888 pixels from the host into `ipdc` under `in_valid`/`in_ready` flow control.

## Interface
- `CMD_DEPTH`, 8: op FIFO depth (power of two, ≥2).
- `PIX_COUNT`, 256: pixels per image load (16×16).
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_cmd_valid`  in  1  host op code valid.
- `i_cmd_mode`  in  4  host op code.
- `o_cmd_ready`  out  1  FIFO can accept; asserted when FIFO count < `CMD_DEPTH`.
- `i_pix_valid`  in  1  host pixel valid.
- `i_pix_data`  in  24  host pixel, {R,G,B}.
- `o_pix_ready`  out  1  host pixel accepted.
- `o_op_valid`  out  1  one-cycle op pulse to `ipdc`.
- `o_op_mode`  out  4  op code to `ipdc`.
- `i_op_ready`  in  1  `ipdc` ready pulse.
- `o_in_valid`  out  1  pixel valid to `ipdc`.
- `o_in_data`  out  24  pixel to `ipdc`.
- `i_in_ready`  in  1  `ipdc` accepts pixel.
- `o_busy`  out  1  asserted when state is LOAD or the FIFO is non-empty.
- `o_err`  out  1  sticky protocol error.

## Operation
- **Command FIFO.**
  - A push occurs when `i_cmd_valid && o_cmd_ready`.
  - There is no write-to-read bypass, and no push into a full FIFO even if a pop happens in the same cycle.
- **Ready token `tok`.**
  - Set on any cycle with `i_op_ready`=1, in any state.
  - Cleared when an op is issued. Clear wins over a simultaneous set.
- **`loaded` flag.** Set once a LOAD op (4'h0) has been issued.
- **FSM states: IDLE, LOAD.**
  - **IDLE, when `tok` && FIFO non-empty:** pop the head.
    - Head is LOAD: register `o_op_valid`=1, `o_op_mode`=0, clear `tok`, go to LOAD.
    - Head is non-LOAD and `loaded`=1: issue it (`o_op_valid`=1, `o_op_mode`=head), clear `tok`, stay in IDLE.
    - Head is non-LOAD and `loaded`=0: drop it, set `o_err`, keep `tok`, stay in IDLE.
  - **LOAD:**
    - Combinational pass-through: `o_in_valid`=`i_pix_valid`, `o_in_data`=`i_pix_data`, `o_pix_ready`=`i_in_ready`.
    - Beat counter (width clog2(`PIX_COUNT`)+1) increments on `i_pix_valid && i_in_ready`.
    - On beat `PIX_COUNT`, the counter clears and the FSM returns to IDLE.
    - No ops are issued while in LOAD.
  - **Outside LOAD:** `o_in_valid`=0, `o_in_data`=0, `o_pix_ready`=0.
- **Second LOAD op.** Reloads the image normally; this is not an error.
- **`o_op_mode`** is 0 whenever `o_op_valid`=0.

## Timing
- **Reset values:** `o_op_valid`=0, `o_op_mode`=0, `o_in_valid`=0, `o_in_data`=0, `o_pix_ready`=0, `o_err`=0, `o_busy`=0. Also FIFO empty, `tok`=0, `loaded`=0, counter=0, state IDLE.
- **Reset mid-LOAD:** the load is abandoned immediately. The next cycle shows all reset values, and the next load counts from 0.
- **Issue latency:**
  - Push at cycle t with `tok` already set → `o_op_valid`=1 at cycle t+2.
  - `i_op_ready` at cycle t with FIFO already non-empty → `o_op_valid`=1 at cycle t+2.
- **`o_op_valid`** is high for exactly one cycle per issued op.
- **LOAD entry/exit:**
  - LOAD state (pass-through active) starts the cycle after the LOAD `o_op_valid` pulse.
  - The cycle after the final accepted beat is IDLE, with `o_in_valid`=0.
- **Backpressure:** while `i_in_ready`=0, the counter holds and the host data is not consumed.
- **Back-to-back issue:** the minimum spacing between op pulses is 2 cycles (one pulse, then token reacquire).

## Structure
- Package `ipdc_pkg`:
  - `OP_LOAD`=4'h0 and the remaining op mode constants.
  - `PIX_W`=24.
  - Default `PIX_COUNT`=256.
  - FSM state enum.
- Sub-module `ipdc_cmd_fifo`: synchronous FIFO, width 4, depth `CMD_DEPTH`, with push/pop/full/empty/count. Instantiated once.
- The FSM, token, `loaded` flag, beat counter and pass-through muxing live in the top level.

## Test plan
- **Basic load:** reset; pulse `i_op_ready`; push 4'h0; supply pixels 0x000000..0x0000FF with `i_in_ready`=1 → one `o_op_valid` pulse with mode 0, then exactly 256 in-order beats, then IDLE and `o_busy`=0.
- **Backpressure:** during LOAD, toggle `i_in_ready` 1/0 each cycle with `i_pix_valid`=1 → `o_pix_ready` mirrors `i_in_ready`, exactly 256 beats accepted, FSM exits after the 512th LOAD cycle.
- **Full FIFO and pacing:**
  - After a load, push 8 ops (4'h1..4'h8) with no `i_op_ready` → `o_cmd_ready`=0 and a 9th push stalls.
  - Each subsequent `i_op_ready` pulse yields exactly one `o_op_valid` two cycles later, in FIFO order.
- **Op before load:** first push is 4'h3 after reset, with token set → no `o_op_valid`, op dropped, `o_err`=1 (sticky); a following 4'h0 issues normally.
- **Reset mid-LOAD:** assert `i_rst` at beat 100 → all outputs 0 next cycle; a new load accepts a full 256 beats.
- **Token before push:** `i_op_ready` pulse while the FIFO is empty → token held; push 4'h0 ten cycles later → `o_op_valid` two cycles after the push.
